// File: rtl/slow_clock_gen_pkg.sv
// Shared definitions for the slow clock generator: FSM states, default board clock,
// and a helper that sizes the down-stream counters.
package slow_clock_gen_pkg;

  localparam int DEFAULT_CLK_HZ = 100_000_000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    STEP_HI = 3'd3,
    STEP_LO = 3'd4
  } state_t;

  // Width of a counter that must hold values 0..n-1 with one spare bit of headroom.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/slow_clock_gen_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-sample counter and a one-cycle
// pulse when the accepted level goes from 0 to 1. Also used for the keypad buttons.
module btn_debounce
  import slow_clock_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clk domain before anything looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive samples disagree with the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/slow_clock_gen.sv
// Slow square-wave generator feeding the ATM counter clock: free-runs while run_sw is
// high, and a debounced press of step_btn produces exactly one slow period while paused.
module slow_clock_gen
  import slow_clock_gen_pkg::*;
#(
  parameter int CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int SLOW_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_sw,
  input  logic step_btn,
  output logic slow_clk,
  output logic tick,
  output logic running
);

  localparam int HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int DW   = cnt_width(HALF);
  localparam logic [DW-1:0] TERM = DW'(HALF - 1);

  logic          run_s1;
  logic          run_sync;
  logic          step_req;
  state_t        state;
  state_t        state_n;
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;
  logic          slow_n;
  logic          tick_n;
  logic          term;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clk  (clk),
    .rst  (rst),
    .btn  (step_btn),
    .pulse(step_req)
  );

  // Two-flop synchroniser for the run switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_s1   <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_s1   <= run_sw;
      run_sync <= run_s1;
    end
  end

  assign term    = (div == TERM);
  assign running = (state == RUN);

  // State, divider and both clock outputs are registered so slow_clk is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      slow_clk <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_n;
      div      <= div_n;
      slow_clk <= slow_n;
      tick     <= tick_n;
    end
  end

  // Next state; every phase starts with the divider at zero and ends on its terminal count.
  always_comb begin
    state_n = state;
    div_n   = div + 1'b1;
    slow_n  = slow_clk;
    tick_n  = 1'b0;
    unique case (state)
      IDLE: begin
        div_n  = '0;
        slow_n = 1'b0;
        if (run_sync) begin
          state_n = RUN;
          slow_n  = 1'b1;
          tick_n  = 1'b1;
        end else if (step_req) begin
          state_n = STEP_HI;
          slow_n  = 1'b1;
          tick_n  = 1'b1;
        end
      end
      RUN: begin
        if (!run_sync) begin
          if (slow_clk && !term) begin
            state_n = DRAIN;
          end else begin
            state_n = IDLE;
            slow_n  = 1'b0;
            div_n   = '0;
          end
        end else if (term) begin
          slow_n = ~slow_clk;
          tick_n = ~slow_clk;
          div_n  = '0;
        end
      end
      DRAIN: begin
        if (term) begin
          state_n = IDLE;
          slow_n  = 1'b0;
          div_n   = '0;
        end
      end
      STEP_HI: begin
        if (term) begin
          state_n = STEP_LO;
          slow_n  = 1'b0;
          div_n   = '0;
        end
      end
      STEP_LO: begin
        if (term) begin
          state_n = IDLE;
          div_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        slow_n  = 1'b0;
        div_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_slow_clock_gen.sv
// Self-checking bench for slow_clock_gen: directed scenarios plus random traffic, all
// compared every cycle against a phase-countdown reference model.
module tb_slow_clock_gen;

  localparam int CLK_HZ  = 20;
  localparam int SLOW_HZ = 2;
  localparam int DEB     = 4;
  localparam int HALF    = CLK_HZ / (2 * SLOW_HZ);

  logic clk = 1'b0;
  logic rst;
  logic run_sw;
  logic step_btn;
  logic slow_clk;
  logic tick;
  logic running;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: mode 0 idle, 1 run, 2 drain, 3 single step.
  int m_mode;
  int m_left;
  bit m_high;
  bit m_tick;
  bit m_second;
  bit run_d1, run_d2, btn_d1, btn_d2;
  bit deb_level;
  bit req_pend;
  bit win[$];

  int cyc;
  int tick_total;
  int high_total;
  int rise_cyc;
  int start_cyc;
  bit prev_slow;
  bit rs_rand;

  always #5 clk = ~clk;

  slow_clock_gen #(
    .CLK_HZ         (CLK_HZ),
    .SLOW_HZ        (SLOW_HZ),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run_sw  (run_sw),
    .step_btn(step_btn),
    .slow_clk(slow_clk),
    .tick    (tick),
    .running (running)
  );

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  task modelReset();
    m_mode    = 0;
    m_left    = 0;
    m_high    = 0;
    m_tick    = 0;
    m_second  = 0;
    run_d1    = 0;
    run_d2    = 0;
    btn_d1    = 0;
    btn_d2    = 0;
    deb_level = 0;
    req_pend  = 0;
    win.delete();
  endtask

  // One clk edge of the reference model, using the inputs present at that edge.
  task modelEdge();
    bit run_now;
    bit req_now;
    bit s;
    bit all_flip;
    if (rst) begin
      modelReset();
      return;
    end
    run_now = run_d2;
    req_now = req_pend;
    s       = btn_d2;
    run_d2  = run_d1;
    run_d1  = run_sw;
    btn_d2  = btn_d1;
    btn_d1  = step_btn;

    win.push_back(s);
    if (win.size() > DEB) void'(win.pop_front());
    req_pend = 0;
    all_flip = (win.size() == DEB);
    foreach (win[i]) if (win[i] == deb_level) all_flip = 0;
    if (all_flip) begin
      deb_level = !deb_level;
      req_pend  = deb_level;
    end

    m_tick = 0;
    case (m_mode)
      0: begin
        if (run_now || req_now) begin
          m_mode   = run_now ? 1 : 3;
          m_second = 0;
          m_high   = 1;
          m_tick   = 1;
          m_left   = HALF;
        end
      end
      1: begin
        if (m_left == 1) begin
          if (!run_now) begin
            m_mode = 0;
            m_high = 0;
          end else begin
            m_high = !m_high;
            m_tick = m_high;
            m_left = HALF;
          end
        end else if (!run_now) begin
          if (m_high) begin
            m_mode = 2;
            m_left--;
          end else begin
            m_mode = 0;
            m_high = 0;
          end
        end else begin
          m_left--;
        end
      end
      2: begin
        if (m_left == 1) begin
          m_mode = 0;
          m_high = 0;
        end else begin
          m_left--;
        end
      end
      default: begin
        if (m_left == 1) begin
          if (!m_second) begin
            m_second = 1;
            m_high   = 0;
            m_left   = HALF;
          end else begin
            m_mode = 0;
          end
        end else begin
          m_left--;
        end
      end
    endcase
  endtask

  task applyStimulus(input bit r, input bit rs, input bit sb, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = r;
      run_sw   = rs;
      step_btn = sb;
      @(posedge clk);
      modelEdge();
      cyc++;
      #1;
      checkOutput("slow_clk", slow_clk, m_high);
      checkOutput("tick", tick, m_tick);
      checkOutput("running", running, m_mode == 1);
      if (tick === 1'b1) tick_total++;
      if (slow_clk === 1'b1) high_total++;
      if (slow_clk === 1'b1 && !prev_slow && rise_cyc < 0) rise_cyc = cyc;
      prev_slow = (slow_clk === 1'b1);
    end
  endtask

  task clearCounts();
    tick_total = 0;
    high_total = 0;
    rise_cyc   = -1;
    start_cyc  = cyc;
  endtask

  initial begin
    rst      = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    cyc      = 0;
    prev_slow = 0;
    modelReset();
    clearCounts();

    // Reset state, then stays quiet while idle.
    applyStimulus(1, 0, 0, 3);
    checkOutput("reset_slow_clk", slow_clk, 0);
    checkOutput("reset_tick", tick, 0);
    checkOutput("reset_running", running, 0);
    clearCounts();
    applyStimulus(0, 0, 0, 50);
    checkOutput("idle_high_cycles", high_total, 0);

    // Free run: 3-clk latency, 8 ticks in 80 clk.
    clearCounts();
    applyStimulus(0, 1, 0, 80);
    checkOutput("run_latency", rise_cyc - start_cyc, 3);
    checkOutput("run_ticks", tick_total, 8);
    checkOutput("run_high_cycles", high_total, 40);

    // Drop run_sw early in a high phase: drain it, no further ticks.
    applyStimulus(0, 1, 0, 3);
    clearCounts();
    applyStimulus(0, 0, 0, 20);
    checkOutput("drain_ticks", tick_total, 0);
    checkOutput("drain_high_cycles", high_total, 4);

    // Single step while paused, then glitches that must be rejected.
    clearCounts();
    applyStimulus(0, 0, 1, 6);
    applyStimulus(0, 0, 0, 30);
    checkOutput("step_ticks", tick_total, 1);
    checkOutput("step_high_cycles", high_total, HALF);
    clearCounts();
    for (int g = 0; g < 3; g++) begin
      applyStimulus(0, 0, 1, 2);
      applyStimulus(0, 0, 0, 3);
    end
    applyStimulus(0, 0, 0, 10);
    checkOutput("glitch_high_cycles", high_total, 0);

    // Second accepted press while stepping is dropped.
    clearCounts();
    applyStimulus(0, 0, 1, 4);
    applyStimulus(0, 0, 0, 4);
    applyStimulus(0, 0, 1, 4);
    applyStimulus(0, 0, 0, 30);
    checkOutput("repress_ticks", tick_total, 1);
    checkOutput("repress_high_cycles", high_total, HALF);

    // run_sync and step_req arrive together: RUN wins.
    clearCounts();
    applyStimulus(0, 0, 1, 4);
    applyStimulus(0, 1, 1, 2);
    applyStimulus(0, 1, 0, 21);
    checkOutput("tie_ticks", tick_total, 3);
    checkOutput("tie_running", running, 1);

    // Reset in the second cycle of a high phase, then restart with full latency.
    applyStimulus(0, 1, 0, 1);
    applyStimulus(1, 1, 0, 1);
    checkOutput("midrst_slow_clk", slow_clk, 0);
    checkOutput("midrst_tick", tick, 0);
    checkOutput("midrst_running", running, 0);
    applyStimulus(1, 1, 0, 2);
    clearCounts();
    applyStimulus(0, 1, 0, 10);
    checkOutput("restart_latency", rise_cyc - start_cyc, 3);

    // Random traffic: slow-changing run switch, bouncy button, rare resets.
    rs_rand = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) rs_rand = !rs_rand;
      applyStimulus(($urandom_range(0, 59) == 0), rs_rand, 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
